aes_input_loader: RTL and testbench
===================================

Name: aes_input_loader

Overview:
- Upstream stage of the pipelined AES encoder/decoder.
- Deserialises 32-bit words from a host bus into a 128-bit key and 128-bit state, then issues one block per cycle into the free-running round pipeline.
- Carries a valid token down a shift register matched to pipeline depth, so the consumer knows which pipeline outputs are real blocks.
- Key is sticky: it is loaded once and reused for every subsequent block until it is reloaded.

Parameters:
- PIPE_DEPTH, 11, cycles from state_out/key_out sampled by the encoder to encoder output valid (NUM_ROUNDS+1).
- WORD_W, 32, host word width; fixed at 32, other values unsupported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts word this cycle.
- in_data  in  32  host word.
- in_is_key  in  1  word belongs to key (1) or state (0); sampled with each accepted word.
- state_out  out  128  block presented to encoder (state_t).
- key_out  out  128  key presented to encoder (key_t).
- issue  out  1  one-cycle pulse: state_out/key_out hold a new block this cycle.
- pipe_valid  out  1  issue delayed by PIPE_DEPTH cycles; qualifies encoder out.
- key_loaded  out  1  a complete key has been captured since reset.
- busy  out  1  one or more tokens in flight in the valid shift register.

Behaviour:
- Word order: first accepted word of a group goes to bits [127:96], then [95:64], [63:32], [31:0] (AES column 0 first).
- Word counter: 2 bits, one each for key and state; wraps 3->0 on the fourth word.
- FSM states: IDLE, FILL, ISSUE.
  - IDLE: in_ready=1. On an accepted word go to FILL, counter=1.
  - FILL: in_ready=1; accept words.
    - Key group completing (4th key word): key_out updated, key_loaded<=1, return to IDLE; no issue.
    - State group completing: go to ISSUE if key_loaded=1 (or the same cycle's key completion cannot coexist, since one word/cycle).
    - State group completing with key_loaded=0: discard the state block and return to IDLE. No issue.
  - ISSUE: in_ready=0 for exactly one cycle; issue=1; return to IDLE.
  - Max throughput: one block per 5 cycles.
- in_is_key change mid-group: the partial group of the other kind is abandoned and its counter is cleared; the new word starts the new group at counter=1.
- key_out changes only on key group completion; it is never altered while a state group is mid-fill. Key reload between blocks is legal; blocks already issued keep their key via the encoder's own buffering.
- Valid shift register: PIPE_DEPTH bits. Bit0<=issue; pipe_valid=bit[PIPE_DEPTH-1]; busy=|shift.
- Reset values: in_ready=0 during the reset cycle, then 1 (IDLE); state_out=0; key_out=0; issue=0; pipe_valid=0; key_loaded=0; busy=0; counters=0; shift register cleared.
- Reset mid-fill or with tokens in flight: all of these are dropped and no pipe_valid is emitted for them.
- in_valid while in_ready=0: word not consumed; host must hold it.

Optional Feature:
- Macro: AES_LOADER_CNT_EN.
- Defined:
  - Adds output blk_count [31:0], incremented on each issue, wrapping at 2^32-1 -> 0; reset 0.
  - Adds output drop_count [15:0], incremented on each discarded state group (no key, or abandoned partial group), saturating at 16'hFFFF; reset 0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, then state 00112233445566778899aabbccddeeff -> issue pulses 1 cycle after the 8th word; state_out/key_out match exactly; pipe_valid pulses exactly PIPE_DEPTH=11 cycles later.
- Four state words before any key -> no issue, key_loaded=0, pipe_valid stays 0; drop_count=1 when AES_LOADER_CNT_EN is defined.
- Key loaded, then 3 back-to-back blocks with in_valid held high -> issue every 5 cycles, in_ready low on each ISSUE cycle, 3 pipe_valid pulses spaced 5 apart, busy high throughout.
- Two state words, then a key word (in_is_key=1) -> partial state abandoned; next 4 state words form a fresh block equal to those words only.
- Reset asserted 3 cycles after an issue -> pipe_valid never rises for that block; all outputs return to reset values the next cycle.
- AES_LOADER_CNT_EN defined, blk_count preset near wrap via 2^32 issues (or forced to FFFFFFFF) -> next issue wraps blk_count to 0.

Source files
------------

// File: rtl/aes_input_loader.sv
// Input loader for the pipelined AES core: packs 32-bit host words into key/state
// blocks, issues blocks and tracks in-flight tokens. Optional counters: AES_LOADER_CNT_EN.
module aes_input_loader #(
  parameter int unsigned PIPE_DEPTH = 11,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_is_key,
  output logic [4*WORD_W-1:0]   state_out,
  output logic [4*WORD_W-1:0]   key_out,
  output logic                  issue,
  output logic                  pipe_valid,
  output logic                  key_loaded,
  output logic                  busy
`ifdef AES_LOADER_CNT_EN
  ,
  output logic [31:0]           blk_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned BUF_W = 3 * WORD_W;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE} fsm_t;

  fsm_t                  fsm;
  logic [BUF_W-1:0]      asm_q;
  logic [1:0]            cnt;
  logic                  grp_key;
  logic [PIPE_DEPTH-1:0] shift;
  logic [PIPE_DEPTH-1:0] shift_nxt;
  logic                  accept;

  assign accept     = in_valid & in_ready;
  assign shift_nxt  = {shift[PIPE_DEPTH-2:0], issue};
  assign pipe_valid = shift[PIPE_DEPTH-1];

  // Group assembly, block hand-off and token shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm        <= IDLE;
      in_ready   <= 1'b0;
      asm_q      <= '0;
      cnt        <= 2'd0;
      grp_key    <= 1'b0;
      state_out  <= '0;
      key_out    <= '0;
      issue      <= 1'b0;
      key_loaded <= 1'b0;
      shift      <= '0;
      busy       <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      issue    <= 1'b0;
      shift    <= shift_nxt;
      busy     <= |shift_nxt;
      case (fsm)
        IDLE: begin
          if (accept) begin
            asm_q[BUF_W-1 -: WORD_W] <= in_data;
            grp_key                  <= in_is_key;
            cnt                      <= 2'd1;
            fsm                      <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (in_is_key != grp_key) begin
              // Kind switched mid-group: the new word restarts assembly
              asm_q[BUF_W-1 -: WORD_W] <= in_data;
              grp_key                  <= in_is_key;
              cnt                      <= 2'd1;
            end else if (cnt == 2'd3) begin
              cnt <= 2'd0;
              fsm <= IDLE;
              if (grp_key) begin
                key_out    <= {asm_q, in_data};
                key_loaded <= 1'b1;
              end else if (key_loaded) begin
                state_out <= {asm_q, in_data};
                issue     <= 1'b1;
                in_ready  <= 1'b0;
                fsm       <= ISSUE;
              end
            end else begin
              case (cnt)
                2'd1:    asm_q[2*WORD_W-1 -: WORD_W]  <= in_data;
                2'd2:    asm_q[WORD_W-1:0]            <= in_data;
                default: asm_q[BUF_W-1 -: WORD_W]     <= in_data;
              endcase
              cnt <= cnt + 2'd1;
            end
          end
        end
        ISSUE: begin
          fsm <= IDLE;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_LOADER_CNT_EN
  logic drop;

  // A state group is lost when a key word interrupts it or it completes before any key
  assign drop = accept & (fsm == FILL) & ~grp_key &
                (in_is_key | ((cnt == 2'd3) & ~key_loaded));

  always_ff @(posedge clock) begin
    if (reset) begin
      blk_count  <= 32'd0;
      drop_count <= 16'd0;
    end else begin
      if (issue) blk_count <= blk_count + 32'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_input_loader.sv
// Bench for aes_input_loader: directed vector table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_aes_input_loader;

  localparam int unsigned PIPE_DEPTH = 11;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_is_key = 1'b0;
  logic [31:0]  in_data = 32'd0;
  logic         in_ready;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic         issue;
  logic         pipe_valid;
  logic         key_loaded;
  logic         busy;
`ifdef AES_LOADER_CNT_EN
  logic [31:0]  blk_count;
  logic [15:0]  drop_count;
`endif

  aes_input_loader #(.PIPE_DEPTH(PIPE_DEPTH), .WORD_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_is_key  (in_is_key),
    .state_out  (state_out),
    .key_out    (key_out),
    .issue      (issue),
    .pipe_valid (pipe_valid),
    .key_loaded (key_loaded),
    .busy       (busy)
`ifdef AES_LOADER_CNT_EN
    ,
    .blk_count  (blk_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: current word group as a queue, issue history as a queue
  bit           m_ready;
  bit           m_issue;
  bit           m_kl;
  logic [127:0] m_key;
  logic [127:0] m_state;
  logic [31:0]  grp[$];
  bit           grp_key;
  bit           hist[$];
  int unsigned  m_blk;
  int unsigned  m_drop;

  task automatic model_drop();
    if (m_drop != 32'hFFFF) m_drop++;
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit k, input logic [31:0] d);
    logic [127:0] blk;
    if (rst) begin
      m_ready = 1'b0; m_issue = 1'b0; m_kl = 1'b0;
      m_key = '0; m_state = '0;
      grp.delete(); hist.delete();
      for (int i = 0; i <= PIPE_DEPTH; i++) hist.push_back(1'b0);
      m_blk = 0; m_drop = 0;
    end else begin
      if (hist[0]) m_blk++;
      m_issue = 1'b0;
      if (v && m_ready) begin
        if (grp.size() > 0 && grp_key != k) begin
          if (!grp_key) model_drop();
          grp.delete();
        end
        if (grp.size() == 0) grp_key = k;
        grp.push_back(d);
        if (grp.size() == 4) begin
          blk = {grp[0], grp[1], grp[2], grp[3]};
          if (grp_key) begin
            m_key = blk; m_kl = 1'b1;
          end else if (m_kl) begin
            m_state = blk; m_issue = 1'b1;
          end else begin
            model_drop();
          end
          grp.delete();
        end
      end
      m_ready = !m_issue;
      hist.push_front(m_issue);
      void'(hist.pop_back());
    end
  endtask

  // One clock: drive inputs, advance model, then compare all outputs after the edge
  task automatic cycle(input bit rst, input bit v, input bit k, input logic [31:0] d);
    bit exp_busy;
    reset = rst; in_valid = v; in_is_key = k; in_data = d;
    model_edge(rst, v, k, d);
    @(posedge clock);
    #1;
    exp_busy = 1'b0;
    for (int i = 1; i <= PIPE_DEPTH; i++) exp_busy |= hist[i];
    chk("in_ready",   128'(in_ready),   128'(m_ready));
    chk("issue",      128'(issue),      128'(m_issue));
    chk("pipe_valid", 128'(pipe_valid), 128'(hist[PIPE_DEPTH]));
    chk("busy",       128'(busy),       128'(exp_busy));
    chk("key_loaded", 128'(key_loaded), 128'(m_kl));
    chk("state_out",  state_out,        m_state);
    chk("key_out",    key_out,          m_key);
`ifdef AES_LOADER_CNT_EN
    chk("blk_count",  128'(blk_count),  128'(m_blk));
    chk("drop_count", 128'(drop_count), 128'(m_drop));
`endif
  endtask

  typedef struct {
    bit           rst;
    bit           v;
    bit           k;
    logic [31:0]  d;
    bit           rdy;
    bit           iss;
    bit           kl;
    logic [127:0] key;
    logic [127:0] st;
  } vec_t;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK = 128'h00112233445566778899aabbccddeeff;

  vec_t tbl[15];

  initial begin : main
    int          n;
    int          seen;
    logic [31:0] d_cur;
    bit          k_cur;
    bit          v_cur;
    bit          r_cur;
    bit          acc;
    logic [31:0] w[4];

    // Reset, four state words with no key (dropped), key, state, issue
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h00112233, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h44556677, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h8899aabb, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'hccddeeff, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h00010203, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h04050607, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h08090a0b, 1'b1, 1'b0, 1'b0, 128'h0, 128'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h0c0d0e0f, 1'b1, 1'b0, 1'b1, KEY,    128'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00112233, 1'b1, 1'b0, 1'b1, KEY,    128'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h44556677, 1'b1, 1'b0, 1'b1, KEY,    128'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h8899aabb, 1'b1, 1'b0, 1'b1, KEY,    128'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'hccddeeff, 1'b0, 1'b1, 1'b1, KEY,    BLK};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, KEY,    BLK};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].k, tbl[i].d);
      chk($sformatf("vec%0d in_ready", i),   128'(in_ready),   128'(tbl[i].rdy));
      chk($sformatf("vec%0d issue", i),      128'(issue),      128'(tbl[i].iss));
      chk($sformatf("vec%0d key_loaded", i), 128'(key_loaded), 128'(tbl[i].kl));
      chk($sformatf("vec%0d key_out", i),    key_out,          tbl[i].key);
      chk($sformatf("vec%0d state_out", i),  state_out,        tbl[i].st);
      chk($sformatf("vec%0d pipe_valid", i), 128'(pipe_valid), 128'(0));
    end

    // Pipe latency from the issue cycle (row 13) to pipe_valid
    n = 1;
    while (!pipe_valid && n < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("pipe_latency", 128'(n), 128'(PIPE_DEPTH));
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Three back-to-back blocks with in_valid held high
    d_cur = $urandom;
    for (int i = 0; i < 26; i++) begin
      v_cur = (i < 14);
      acc   = v_cur && m_ready;
      cycle(1'b0, v_cur, 1'b0, d_cur);
      if (acc) d_cur = $urandom;
      chk($sformatf("b2b%0d issue", i),      128'(issue),      128'(i == 3 || i == 8 || i == 13));
      chk($sformatf("b2b%0d pipe_valid", i), 128'(pipe_valid), 128'(i == 14 || i == 19 || i == 24));
      chk($sformatf("b2b%0d busy", i),       128'(busy),       128'(i >= 4 && i <= 24));
    end

    // Partial state group abandoned by a key word, then a fresh state group
    cycle(1'b0, 1'b1, 1'b0, 32'hdead0001);
    cycle(1'b0, 1'b1, 1'b0, 32'hdead0002);
    cycle(1'b0, 1'b1, 1'b1, 32'hbeef0000);
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      cycle(1'b0, 1'b1, 1'b0, w[i]);
    end
    chk("abandon issue",     128'(issue), 128'(1));
    chk("abandon state_out", state_out,   {w[0], w[1], w[2], w[3]});
    chk("abandon key_out",   key_out,     KEY);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset three cycles after an issue drops the token
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0badf00d + 32'(i));
    chk("pre-reset issue", 128'(issue), 128'(1));
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst in_ready",   128'(in_ready),   128'(0));
    chk("rst state_out",  state_out,        128'h0);
    chk("rst key_out",    key_out,          128'h0);
    chk("rst issue",      128'(issue),      128'(0));
    chk("rst pipe_valid", 128'(pipe_valid), 128'(0));
    chk("rst key_loaded", 128'(key_loaded), 128'(0));
    chk("rst busy",       128'(busy),       128'(0));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (pipe_valid) seen++;
    end
    chk("no pipe_valid after reset", 128'(seen), 128'(0));

    // Random traffic; unaccepted words are held, occasional reset
    d_cur = $urandom;
    k_cur = 1'b1;
    v_cur = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r_cur = ($urandom_range(0, 299) == 0);
      acc   = !r_cur && v_cur && m_ready;
      cycle(r_cur, v_cur, k_cur, d_cur);
      if (acc || !v_cur || r_cur) begin
        v_cur = ($urandom_range(0, 3) != 0);
        d_cur = $urandom;
        if ($urandom_range(0, 9) == 0) k_cur = !k_cur;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
